// File: rtl/conv_kernel_ctrl.sv
// Per-sample kernel-walk sequencer: for every output pixel, walks the kernel
// window across all input channels, one input/weight address pair per cycle.
module conv_kernel_ctrl #(
   parameter int AW = 12,
   parameter int WW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          s_init,
   input  logic          out_busy,
   input  logic [3:0]    id,
   input  logic [3:0]    kw,
   input  logic [3:0]    kh,
   input  logic [WW-1:0] ow,
   input  logic [WW-1:0] oh,
   input  logic [WW-1:0] iw,
   input  logic [AW-1:0] is,
   output logic          exec,
   output logic [AW-1:0] ia,
   output logic [WW-1:0] wa,
   output logic          k_init,
   output logic          k_fin,
   output logic          s_fin,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [WW-1:0] W_ONE = WW'(1);

   state_t        state_q, state_d;
   logic          issue;

   // Counters and running bases describe the position of the NEXT exec.
   logic [3:0]    kx_q, kx_d, ky_q, ky_d, ic_q, ic_d;
   logic [WW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [AW-1:0] line_q, line_d, pix_q, pix_d, ch_q, ch_d, row_q, row_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [WW-1:0] wcnt_q, wcnt_d;

   // Registered outputs describe the exec currently on the bus.
   logic [AW-1:0] ia_q, ia_d;
   logic [WW-1:0] wa_q, wa_d;
   logic          k_init_q, k_init_d, k_fin_q, k_fin_d, last_q, last_d;

   logic          at_kx, at_ky, at_ic, at_ox, at_oy, pix_end;
   logic [AW-1:0] iw_a;

   assign iw_a    = AW'(iw);
   assign at_kx   = (kx_q == kw);
   assign at_ky   = (ky_q == kh);
   assign at_ic   = (ic_q == id);
   assign at_ox   = (ox_q == ow);
   assign at_oy   = (oy_q == oh);
   assign pix_end = at_kx && at_ky && at_ic;

   // Handshake: out_busy is only looked at in the k_fin cycle; when high, the
   // next pixel is held in WAIT until a cycle with out_busy low.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s_init) begin
               state_d = S_RUN;
               issue   = 1'b1;
            end
         end
         S_RUN: begin
            if (last_q)                     state_d = S_DONE;
            else if (k_fin_q && out_busy)   state_d = S_WAIT;
            else                            issue   = 1'b1;
         end
         S_WAIT: begin
            if (!out_busy) begin
               state_d = S_RUN;
               issue   = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (!run) begin
         state_d = S_IDLE;
         issue   = 1'b0;
      end
   end

   always_comb begin
      kx_d = kx_q;  ky_d = ky_q;  ic_d = ic_q;
      ox_d = ox_q;  oy_d = oy_q;
      line_d = line_q;  pix_d = pix_q;  ch_d = ch_q;  row_d = row_q;
      addr_d = addr_q;  wcnt_d = wcnt_q;
      ia_d = ia_q;  wa_d = wa_q;
      k_init_d = k_init_q;  k_fin_d = k_fin_q;  last_d = last_q;
      if (!run) begin
         kx_d = '0;  ky_d = '0;  ic_d = '0;  ox_d = '0;  oy_d = '0;
         line_d = '0;  pix_d = '0;  ch_d = '0;  row_d = '0;
         addr_d = '0;  wcnt_d = '0;  ia_d = '0;  wa_d = '0;
         k_init_d = 1'b0;  k_fin_d = 1'b0;  last_d = 1'b0;
      end else if (issue) begin
         ia_d     = addr_q;
         wa_d     = wcnt_q;
         k_init_d = (kx_q == 4'd0) && (ky_q == 4'd0) && (ic_q == 4'd0);
         k_fin_d  = pix_end;
         last_d   = pix_end && at_ox && at_oy;
         wcnt_d   = pix_end ? '0 : wcnt_q + W_ONE;
         // Each carry level restarts all inner bases from its own new base.
         if (!at_kx) begin
            kx_d   = kx_q + 4'd1;
            addr_d = addr_q + A_ONE;
         end else begin
            kx_d = '0;
            if (!at_ky) begin
               ky_d   = ky_q + 4'd1;
               row_d  = row_q + iw_a;
               addr_d = row_q + iw_a;
            end else begin
               ky_d = '0;
               if (!at_ic) begin
                  ic_d   = ic_q + 4'd1;
                  ch_d   = ch_q + is;
                  row_d  = ch_q + is;
                  addr_d = ch_q + is;
               end else begin
                  ic_d = '0;
                  if (!at_ox) begin
                     ox_d   = ox_q + W_ONE;
                     pix_d  = pix_q + A_ONE;
                     ch_d   = pix_q + A_ONE;
                     row_d  = pix_q + A_ONE;
                     addr_d = pix_q + A_ONE;
                  end else begin
                     ox_d = '0;
                     if (!at_oy) begin
                        oy_d   = oy_q + W_ONE;
                        line_d = line_q + iw_a;
                        pix_d  = line_q + iw_a;
                        ch_d   = line_q + iw_a;
                        row_d  = line_q + iw_a;
                        addr_d = line_q + iw_a;
                     end else begin
                        oy_d = '0;  line_d = '0;  pix_d = '0;
                        ch_d = '0;  row_d = '0;  addr_d = '0;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx_q <= '0;  ky_q <= '0;  ic_q <= '0;  ox_q <= '0;  oy_q <= '0;
         line_q <= '0;  pix_q <= '0;  ch_q <= '0;  row_q <= '0;
         addr_q <= '0;  wcnt_q <= '0;  ia_q <= '0;  wa_q <= '0;
         k_init_q <= 1'b0;  k_fin_q <= 1'b0;  last_q <= 1'b0;
      end else begin
         kx_q <= kx_d;  ky_q <= ky_d;  ic_q <= ic_d;  ox_q <= ox_d;  oy_q <= oy_d;
         line_q <= line_d;  pix_q <= pix_d;  ch_q <= ch_d;  row_q <= row_d;
         addr_q <= addr_d;  wcnt_q <= wcnt_d;  ia_q <= ia_d;  wa_q <= wa_d;
         k_init_q <= k_init_d;  k_fin_q <= k_fin_d;  last_q <= last_d;
      end
   end

   assign exec      = (state_q == S_RUN);
   assign ia        = ia_q;
   assign wa        = wa_q;
   assign k_init    = exec && k_init_q;
   assign k_fin     = exec && k_fin_q;
   assign s_fin     = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Directed bench for conv_kernel_ctrl: hand-computed spot values per scenario
// plus a closed-form ia/wa model checked against every captured exec cycle.
module tb_conv_kernel_ctrl;

   localparam int AW = 12;
   localparam int WW = 10;
   localparam int MAXC = 256;

   logic          clk = 1'b0;
   logic          rst, run, s_init, out_busy;
   logic [3:0]    id, kw, kh;
   logic [WW-1:0] ow, oh, iw;
   logic [AW-1:0] is;
   logic          exec, k_init, k_fin, s_fin, busy;
   logic [AW-1:0] ia;
   logic [WW-1:0] wa;
   logic [1:0]    dbg_state;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] cap_ex [MAXC];
   logic [31:0] cap_ia [MAXC];
   logic [31:0] cap_wa [MAXC];
   logic [31:0] cap_ki [MAXC];
   logic [31:0] cap_kf [MAXC];
   logic [31:0] cap_sf [MAXC];
   logic [31:0] cap_bz [MAXC];

   conv_kernel_ctrl #(.AW(AW), .WW(WW)) dut (
      .clk(clk), .rst(rst), .run(run), .s_init(s_init), .out_busy(out_busy),
      .id(id), .kw(kw), .kh(kh), .ow(ow), .oh(oh), .iw(iw), .is(is),
      .exec(exec), .ia(ia), .wa(wa), .k_init(k_init), .k_fin(k_fin),
      .s_fin(s_fin), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int c_id, input int c_kw, input int c_kh, input int c_ow,
                      input int c_oh, input int c_iw, input int c_is);
      id = 4'(c_id);  kw = 4'(c_kw);  kh = 4'(c_kh);
      ow = WW'(c_ow); oh = WW'(c_oh); iw = WW'(c_iw); is = AW'(c_is);
   endtask

   // s_init in cycle 0; cycle c is captured just after the edge that starts it.
   task automatic walk(input int ncyc, input int busy_lo, input int busy_hi,
                       input int drop_at, input int dup_at);
      for (int c = 0; c < MAXC; c++) begin
         cap_ex[c] = 'x; cap_ia[c] = 'x; cap_wa[c] = 'x; cap_ki[c] = 'x;
         cap_kf[c] = 'x; cap_sf[c] = 'x; cap_bz[c] = 'x;
      end
      s_init = 1'b1; run = 1'b1; out_busy = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         cap_ex[c] = 32'(exec);   cap_ia[c] = 32'(ia);     cap_wa[c] = 32'(wa);
         cap_ki[c] = 32'(k_init); cap_kf[c] = 32'(k_fin);  cap_sf[c] = 32'(s_fin);
         cap_bz[c] = 32'(busy);
         s_init   = (c == dup_at);
         out_busy = (c >= busy_lo) && (c <= busy_hi);
         if (c == drop_at) run = 1'b0;
      end
      s_init = 1'b0; out_busy = 1'b0; run = 1'b1;
   endtask

   // Closed-form expectation; stall cycles are inserted after the first pixel.
   task automatic check_walk(input string tag, input int stall);
      int v_id, v_kw, v_kh, v_ow, v_oh, v_iw, v_is;
      int n, nexec, r, e_kx, e_ky, e_ic, e_ox, e_oy, e_ia, c, cl, cnt;
      v_id = int'(id); v_kw = int'(kw); v_kh = int'(kh);
      v_ow = int'(ow); v_oh = int'(oh); v_iw = int'(iw); v_is = int'(is);
      n = (v_id + 1) * (v_kh + 1) * (v_kw + 1);
      nexec = (v_ow + 1) * (v_oh + 1) * n;
      for (int t = 0; t < nexec; t++) begin
         r = t;
         e_kx = r % (v_kw + 1); r = r / (v_kw + 1);
         e_ky = r % (v_kh + 1); r = r / (v_kh + 1);
         e_ic = r % (v_id + 1); r = r / (v_id + 1);
         e_ox = r % (v_ow + 1); r = r / (v_ow + 1);
         e_oy = r;
         e_ia = (e_ic * v_is + (e_oy + e_ky) * v_iw + e_ox + e_kx) % (1 << AW);
         c = 1 + t + ((t >= n) ? stall : 0);
         check($sformatf("%s exec t%0d", tag, t), cap_ex[c], 1);
         check($sformatf("%s ia t%0d", tag, t), cap_ia[c], 32'(e_ia));
         check($sformatf("%s wa t%0d", tag, t), cap_wa[c], 32'((t % n) % (1 << WW)));
         check($sformatf("%s k_init t%0d", tag, t), cap_ki[c],
               32'(e_kx == 0 && e_ky == 0 && e_ic == 0));
         check($sformatf("%s k_fin t%0d", tag, t), cap_kf[c],
               32'(e_kx == v_kw && e_ky == v_kh && e_ic == v_id));
      end
      cl = nexec + ((nexec > n) ? stall : 0);
      check({tag, " s_fin end"}, cap_sf[cl + 1], 1);
      check({tag, " exec in done"}, cap_ex[cl + 1], 0);
      check({tag, " busy after"}, cap_bz[cl + 2], 0);
      for (int s = n + 1; s <= n + stall; s++) begin
         check($sformatf("%s exec wait c%0d", tag, s), cap_ex[s], 0);
         check($sformatf("%s s_fin wait c%0d", tag, s), cap_sf[s], 0);
      end
      cnt = 0;
      for (int s = 1; s <= cl + 2; s++) if (cap_ex[s] === 32'd1) cnt++;
      check({tag, " exec count"}, 32'(cnt), 32'(nexec));
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; s_init = 1'b0; out_busy = 1'b0;
      cfg(0, 1, 1, 2, 2, 4, 16);
      tick(); tick();
      check("rst exec", 32'(exec), 0);
      check("rst ia", 32'(ia), 0);
      check("rst wa", 32'(wa), 0);
      check("rst k_init", 32'(k_init), 0);
      check("rst k_fin", 32'(k_fin), 0);
      check("rst s_fin", 32'(s_fin), 0);
      check("rst busy", 32'(busy), 0);
      rst = 1'b0;
      tick();

      // Scenario 1: 2x2 kernel, one channel, 3x3 outputs
      walk(40, 0, -1, 0, 0);
      check("t1 ia c1", cap_ia[1], 0);
      check("t1 ia c2", cap_ia[2], 1);
      check("t1 ia c3", cap_ia[3], 4);
      check("t1 ia c4", cap_ia[4], 5);
      check("t1 ia c5", cap_ia[5], 1);
      check("t1 ia c8", cap_ia[8], 6);
      check("t1 ia c13", cap_ia[13], 4);
      check("t1 ia c16", cap_ia[16], 9);
      check("t1 k_init c1", cap_ki[1], 1);
      check("t1 k_fin c4", cap_kf[4], 1);
      check("t1 k_fin c3", cap_kf[3], 0);
      check("t1 wa c8", cap_wa[8], 3);
      check("t1 s_fin c37", cap_sf[37], 1);
      check("t1 s_fin c36", cap_sf[36], 0);
      check("t1 busy c37", cap_bz[37], 1);
      check("t1 busy c38", cap_bz[38], 0);
      check_walk("t1", 0);

      // Scenario 2: two channels, plus a stray s_init mid-walk that must be ignored
      cfg(1, 1, 1, 2, 2, 4, 16);
      walk(76, 0, -1, 0, 5);
      check("t2 ia c5", cap_ia[5], 16);
      check("t2 ia c8", cap_ia[8], 21);
      check("t2 wa c8", cap_wa[8], 7);
      check("t2 k_fin c8", cap_kf[8], 1);
      check("t2 k_fin c4", cap_kf[4], 0);
      check("t2 s_fin c73", cap_sf[73], 1);
      check_walk("t2", 0);

      // Scenario 3: out_busy high at the first pixel boundary, low from cycle 9
      cfg(0, 1, 1, 2, 2, 4, 16);
      walk(46, 4, 8, 0, 0);
      check("t3 exec c5", cap_ex[5], 0);
      check("t3 exec c9", cap_ex[9], 0);
      check("t3 ia hold c7", cap_ia[7], 5);
      check("t3 ia c10", cap_ia[10], 1);
      check("t3 k_init c10", cap_ki[10], 1);
      check("t3 s_fin c37", cap_sf[37], 0);
      check("t3 s_fin c42", cap_sf[42], 1);
      check_walk("t3", 5);

      // Scenario 4: single-tap kernel, two output pixels
      cfg(0, 0, 0, 1, 0, 4, 16);
      walk(6, 0, -1, 0, 0);
      check("t4 ia c1", cap_ia[1], 0);
      check("t4 ia c2", cap_ia[2], 1);
      check("t4 kinit c1", cap_ki[1], 1);
      check("t4 kfin c1", cap_kf[1], 1);
      check("t4 kinit c2", cap_ki[2], 1);
      check("t4 kfin c2", cap_kf[2], 1);
      check("t4 s_fin c3", cap_sf[3], 1);
      check_walk("t4", 0);

      // Scenario 5: run dropped in cycle 10, then a fresh walk
      cfg(0, 1, 1, 2, 2, 4, 16);
      walk(14, 0, -1, 10, 0);
      check("t5 exec c10", cap_ex[10], 1);
      check("t5 ia c10", cap_ia[10], 3);
      check("t5 exec c11", cap_ex[11], 0);
      check("t5 busy c11", cap_bz[11], 0);
      check("t5 s_fin c11", cap_sf[11], 0);
      check("t5 ia c11", cap_ia[11], 0);
      check("t5 s_fin c13", cap_sf[13], 0);
      walk(40, 0, -1, 0, 0);
      check("t5 restart ia", cap_ia[1], 0);
      check("t5 restart wa", cap_wa[1], 0);
      check("t5 restart k_init", cap_ki[1], 1);
      check_walk("t5r", 0);

      // Scenario 6: asynchronous reset in the middle of a RUN cycle
      s_init = 1'b1; run = 1'b1;
      tick();
      s_init = 1'b0;
      tick(); tick();
      check("t6 pre exec", 32'(exec), 1);
      check("t6 pre ia", 32'(ia), 4);
      #3;
      rst = 1'b1;
      #1;
      check("t6 async exec", 32'(exec), 0);
      check("t6 async ia", 32'(ia), 0);
      check("t6 async wa", 32'(wa), 0);
      check("t6 async k_init", 32'(k_init), 0);
      check("t6 async busy", 32'(busy), 0);
      #1;
      rst = 1'b0;
      run = 1'b0; s_init = 1'b1;
      tick();
      check("t6 run0 exec", 32'(exec), 0);
      check("t6 run0 busy", 32'(busy), 0);
      run = 1'b1; s_init = 1'b0;
      tick();
      check("t6 idle exec", 32'(exec), 0);
      check("t6 idle busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
